// File: rtl/del_mut_engine.sv
// del_mut_engine: streaming deletion mutator for a genome of node and
// connection genes. Hidden nodes are randomly deleted and their ids are kept
// in a small list; connection genes that touch a listed node (or lose their
// own random draw) are dropped or disabled. One register stage sits between
// the input and output streams.
//
// Handshake: a word moves across an interface only in a cycle where both
// valid and ready are high. The sender holds valid and its payload steady
// until that cycle. Ready may depend on the receiver's own state and on
// start, never on in_valid.
module del_mut_engine #(
    parameter int GENE_SZ   = 64,
    parameter int ATTR_SZ   = 8,
    parameter int DEL_DEPTH = 8,
    parameter int CONN_MODE = 0,
    parameter int EN_BIT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ATTR_SZ-1:0] node_del_prob,
    input  logic [ATTR_SZ-1:0] conn_del_prob,
    input  logic               phase,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [GENE_SZ-1:0] gene_in,
    input  logic               in_last,
    input  logic [ATTR_SZ-1:0] rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GENE_SZ-1:0] gene_out,
    output logic               done,
    output logic [ATTR_SZ-1:0] del_node_cnt,
    output logic [ATTR_SZ-1:0] del_conn_cnt,
    output logic               list_full
);

    localparam logic [ATTR_SZ-1:0] CNT_MAX = '1;

    logic [ATTR_SZ-1:0] node_prob_reg;
    logic [ATTR_SZ-1:0] conn_prob_reg;
    logic [ATTR_SZ-1:0] list_id [DEL_DEPTH];
    logic [DEL_DEPTH-1:0] list_vld;

    logic               accept;
    logic [ATTR_SZ-1:0] f_id;
    logic [ATTR_SZ-1:0] f_dest;
    logic [1:0]         f_type;
    logic               list_has_room;
    logic               match;
    logic               node_del;
    logic               conn_del;
    logic               emit;
    logic [GENE_SZ-1:0] emit_word;

    // Gene field extraction; node_id and src share the same slot.
    assign f_id   = gene_in[6*ATTR_SZ-1 -: ATTR_SZ];
    assign f_dest = gene_in[5*ATTR_SZ-1 -: ATTR_SZ];
    assign f_type = gene_in[7*ATTR_SZ-2 -: 2];

    // A stalled output word blocks new input; start takes priority over input.
    assign in_ready = !rst && !start && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // The list index equals the deletion count, so the count bounds the list.
    assign list_has_room = 32'(del_node_cnt) < 32'(DEL_DEPTH);
    assign list_full     = !list_has_room;

    // Compare src and dest against every valid list entry.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEL_DEPTH; i++) begin
            if (list_vld[i] && (list_id[i] == f_id || list_id[i] == f_dest)) begin
                match = 1'b1;
            end
        end
    end

    // Decide per beat whether the gene is deleted and what, if anything, is emitted.
    always_comb begin
        node_del  = 1'b0;
        conn_del  = 1'b0;
        emit      = 1'b0;
        emit_word = gene_in;
        if (!phase) begin
            node_del = (rnd > node_prob_reg) && list_has_room && (f_type == 2'b00);
            emit     = !node_del;
        end else begin
            conn_del = match || (rnd > conn_prob_reg);
            if (!conn_del) begin
                emit = 1'b1;
            end else if (CONN_MODE == 1) begin
                emit              = 1'b1;
                emit_word[EN_BIT] = 1'b0;
            end
        end
    end

    // Probability latches, list valid bits and deletion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            node_prob_reg <= '0;
            conn_prob_reg <= '0;
            list_vld      <= '0;
            del_node_cnt  <= '0;
            del_conn_cnt  <= '0;
        end else if (start) begin
            node_prob_reg <= node_del_prob;
            conn_prob_reg <= conn_del_prob;
            list_vld      <= '0;
            del_node_cnt  <= '0;
            del_conn_cnt  <= '0;
        end else if (accept) begin
            if (node_del) begin
                for (int i = 0; i < DEL_DEPTH; i++) begin
                    if (32'(del_node_cnt) == 32'(i)) begin
                        list_vld[i] <= 1'b1;
                    end
                end
                if (del_node_cnt != CNT_MAX) begin
                    del_node_cnt <= del_node_cnt + 1'b1;
                end
            end
            if (conn_del && del_conn_cnt != CNT_MAX) begin
                del_conn_cnt <= del_conn_cnt + 1'b1;
            end
        end
    end

    // Deleted node ids; contents are only meaningful where list_vld is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEL_DEPTH; i++) begin
            if (accept && node_del && 32'(del_node_cnt) == 32'(i)) begin
                list_id[i] <= f_id;
            end
        end
    end

    // Output register stage and end-of-genome pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            gene_out  <= '0;
            done      <= 1'b0;
        end else if (start) begin
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= accept && phase && in_last;
            if (accept) begin
                out_valid <= emit;
                if (emit) begin
                    gene_out <= emit_word;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_del_mut_engine.sv
// Directed bench for del_mut_engine. Two instances share all inputs: one
// drops deleted connections, the other forwards them with bit 0 cleared.
module tb_del_mut_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  node_del_prob;
    logic [7:0]  conn_del_prob;
    logic        phase;
    logic        in_valid;
    logic [63:0] gene_in;
    logic        in_last;
    logic [7:0]  rnd;
    logic        out_ready;

    logic        in_ready_0, out_valid_0, done_0, list_full_0;
    logic [63:0] gene_out_0;
    logic [7:0]  del_node_cnt_0, del_conn_cnt_0;
    logic        in_ready_1, out_valid_1, done_1, list_full_1;
    logic [63:0] gene_out_1;
    logic [7:0]  del_node_cnt_1, del_conn_cnt_1;

    int n_pass  = 0;
    int n_total = 0;

    // Clock generation.
    always #5 clk = ~clk;

    del_mut_engine #(.GENE_SZ(64), .ATTR_SZ(8), .DEL_DEPTH(8), .CONN_MODE(0), .EN_BIT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .node_del_prob(node_del_prob),
        .conn_del_prob(conn_del_prob), .phase(phase), .in_valid(in_valid),
        .in_ready(in_ready_0), .gene_in(gene_in), .in_last(in_last), .rnd(rnd),
        .out_valid(out_valid_0), .out_ready(out_ready), .gene_out(gene_out_0),
        .done(done_0), .del_node_cnt(del_node_cnt_0), .del_conn_cnt(del_conn_cnt_0),
        .list_full(list_full_0)
    );

    del_mut_engine #(.GENE_SZ(64), .ATTR_SZ(8), .DEL_DEPTH(8), .CONN_MODE(1), .EN_BIT(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .node_del_prob(node_del_prob),
        .conn_del_prob(conn_del_prob), .phase(phase), .in_valid(in_valid),
        .in_ready(in_ready_1), .gene_in(gene_in), .in_last(in_last), .rnd(rnd),
        .out_valid(out_valid_1), .out_ready(out_ready), .gene_out(gene_out_1),
        .done(done_1), .del_node_cnt(del_node_cnt_1), .del_conn_cnt(del_conn_cnt_1),
        .list_full(list_full_1)
    );

    // Build a gene: type at [54:53], id/src at [47:40], dest at [39:32], low byte at [7:0].
    function automatic logic [63:0] mk(input logic [1:0] t, input logic [7:0] id,
                                       input logic [7:0] dst, input logic [7:0] low);
        logic [63:0] g;
        g        = '0;
        g[54:53] = t;
        g[47:40] = id;
        g[39:32] = dst;
        g[7:0]   = low;
        return g;
    endfunction

    // Present one beat for one cycle; returns at the negedge after it was taken.
    task automatic send(input logic ph, input logic [63:0] g, input logic last, input logic [7:0] r);
        @(negedge clk);
        phase = ph; gene_in = g; in_last = last; rnd = r; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Pulse start with new thresholds.
    task automatic do_start(input logic [7:0] np, input logic [7:0] cp);
        @(negedge clk);
        start = 1'b1; node_del_prob = np; conn_del_prob = cp;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; node_del_prob = '0; conn_del_prob = '0;
        phase = 1'b0; in_valid = 1'b0; gene_in = '0; in_last = 1'b0; rnd = '0;
        out_ready = 1'b1;
        #12;
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid_0); else n_pass++;
        n_total++; if (gene_out_0 !== 64'h0) $display("FAIL rst_gene_out: got %h want 0", gene_out_0); else n_pass++;
        n_total++; if (done_0 !== 1'b0) $display("FAIL rst_done: got %b want 0", done_0); else n_pass++;
        n_total++; if (del_node_cnt_0 !== 8'h00 || del_conn_cnt_0 !== 8'h00)
            $display("FAIL rst_counts: got %h/%h want 00/00", del_node_cnt_0, del_conn_cnt_0); else n_pass++;
        n_total++; if (list_full_0 !== 1'b0) $display("FAIL rst_list_full: got %b want 0", list_full_0); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (in_ready_0 !== 1'b1 || in_ready_1 !== 1'b1)
            $display("FAIL rst_in_ready: got %b/%b want 1/1", in_ready_0, in_ready_1); else n_pass++;
    endtask

    task automatic test_node_conn_delete();
        logic [63:0] g;
        do_start(8'h80, 8'hFF);
        g = mk(2'b00, 8'h06, 8'h00, 8'h11);
        send(1'b0, g, 1'b0, 8'h80);
        n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== g)
            $display("FAIL node_rnd_eq_prob: got v=%b %h want v=1 %h", out_valid_0, gene_out_0, g); else n_pass++;
        send(1'b0, mk(2'b00, 8'h05, 8'h00, 8'h22), 1'b0, 8'h90);
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL node_del_valid: got %b want 0", out_valid_0); else n_pass++;
        n_total++; if (del_node_cnt_0 !== 8'd1) $display("FAIL node_del_cnt: got %0d want 1", del_node_cnt_0); else n_pass++;
        g = mk(2'b00, 8'h05, 8'h07, 8'h81);
        send(1'b1, g, 1'b0, 8'h00);
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL conn_drop_valid: got %b want 0", out_valid_0); else n_pass++;
        n_total++; if (del_conn_cnt_0 !== 8'd1) $display("FAIL conn_drop_cnt: got %0d want 1", del_conn_cnt_0); else n_pass++;
        n_total++; if (out_valid_1 !== 1'b1 || gene_out_1 !== (g & ~64'h1))
            $display("FAIL conn_disable_src: got v=%b %h want v=1 %h", out_valid_1, gene_out_1, g & ~64'h1); else n_pass++;
        g = mk(2'b00, 8'h09, 8'h0A, 8'h81);
        send(1'b1, g, 1'b0, 8'h00);
        n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== g)
            $display("FAIL conn_keep: got v=%b %h want v=1 %h", out_valid_0, gene_out_0, g); else n_pass++;
        n_total++; if (del_conn_cnt_0 !== 8'd1) $display("FAIL conn_keep_cnt: got %0d want 1", del_conn_cnt_0); else n_pass++;
    endtask

    task automatic test_node_keep();
        logic [63:0] g;
        g = mk(2'b01, 8'h03, 8'h00, 8'h5A);
        send(1'b0, g, 1'b0, 8'hFF);
        n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== g)
            $display("FAIL input_node_keep: got v=%b %h want v=1 %h", out_valid_0, gene_out_0, g); else n_pass++;
    endtask

    task automatic test_list_full();
        logic [63:0] g;
        do_start(8'h00, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            g = mk(2'b00, 8'(8'h10 + i), 8'h00, 8'(i));
            send(1'b0, g, 1'b0, 8'hFF);
            if (i < 8) begin
                n_total++; if (out_valid_0 !== 1'b0) $display("FAIL full_del_%0d: got v=%b want v=0", i, out_valid_0); else n_pass++;
            end else begin
                n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== g)
                    $display("FAIL full_fwd_%0d: got v=%b %h want v=1 %h", i, out_valid_0, gene_out_0, g); else n_pass++;
            end
        end
        n_total++; if (del_node_cnt_0 !== 8'd8) $display("FAIL full_cnt: got %0d want 8", del_node_cnt_0); else n_pass++;
        n_total++; if (list_full_0 !== 1'b1) $display("FAIL full_flag: got %b want 1", list_full_0); else n_pass++;
        send(1'b1, mk(2'b00, 8'h17, 8'h99, 8'h01), 1'b0, 8'h00);
        n_total++; if (out_valid_0 !== 1'b0) $display("FAIL last_entry_match: got v=%b want v=0", out_valid_0); else n_pass++;
        g = mk(2'b00, 8'h18, 8'h19, 8'h01);
        send(1'b1, g, 1'b0, 8'h00);
        n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== g)
            $display("FAIL unlisted_conn: got v=%b %h want v=1 %h", out_valid_0, gene_out_0, g); else n_pass++;
    endtask

    task automatic test_stall();
        logic [63:0] g;
        do_start(8'h00, 8'hFF);
        send(1'b0, mk(2'b00, 8'h21, 8'h00, 8'h00), 1'b0, 8'hFF);
        out_ready = 1'b0;
        g = mk(2'b00, 8'h30, 8'h21, 8'h81);
        send(1'b1, g, 1'b0, 8'h00);
        n_total++; if (out_valid_1 !== 1'b1 || gene_out_1 !== (g & ~64'h1))
            $display("FAIL disable_dest: got v=%b %h want v=1 %h", out_valid_1, gene_out_1, g & ~64'h1); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (out_valid_1 !== 1'b1 || gene_out_1 !== (g & ~64'h1) || in_ready_1 !== 1'b0)
                $display("FAIL stall_hold_%0d: got v=%b %h rdy=%b want v=1 %h rdy=0",
                         i, out_valid_1, gene_out_1, in_ready_1, g & ~64'h1); else n_pass++;
        end
        n_total++; if (in_ready_0 !== 1'b1) $display("FAIL drop_not_stalled: got %b want 1", in_ready_0); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++; if (out_valid_1 !== 1'b0) $display("FAIL stall_release: got %b want 0", out_valid_1); else n_pass++;
    endtask

    task automatic test_empty_list();
        logic [63:0] g;
        do_start(8'h80, 8'h10);
        g = mk(2'b00, 8'h00, 8'h00, 8'h01);
        send(1'b1, g, 1'b0, 8'h00);
        n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== g)
            $display("FAIL empty_no_match: got v=%b %h want v=1 %h", out_valid_0, gene_out_0, g); else n_pass++;
        send(1'b1, g, 1'b0, 8'h10);
        n_total++; if (out_valid_0 !== 1'b1 || del_conn_cnt_0 !== 8'd0)
            $display("FAIL conn_rnd_eq_prob: got v=%b cnt=%0d want v=1 cnt=0", out_valid_0, del_conn_cnt_0); else n_pass++;
        send(1'b1, g, 1'b0, 8'h11);
        n_total++; if (out_valid_0 !== 1'b0 || del_conn_cnt_0 !== 8'd1)
            $display("FAIL conn_rnd_del: got v=%b cnt=%0d want v=0 cnt=1", out_valid_0, del_conn_cnt_0); else n_pass++;
        n_total++; if (gene_out_1 !== 64'h0 || del_conn_cnt_1 !== 8'd1)
            $display("FAIL conn_rnd_disable: got %h cnt=%0d want 0 cnt=1", gene_out_1, del_conn_cnt_1); else n_pass++;
    endtask

    task automatic test_done();
        logic [63:0] g;
        do_start(8'h00, 8'hFF);
        send(1'b0, mk(2'b01, 8'h33, 8'h00, 8'h00), 1'b1, 8'h00);
        n_total++; if (done_0 !== 1'b0) $display("FAIL node_last_ignored: got %b want 0", done_0); else n_pass++;
        send(1'b0, mk(2'b00, 8'h40, 8'h00, 8'h00), 1'b0, 8'h01);
        send(1'b1, mk(2'b00, 8'h40, 8'h41, 8'h01), 1'b1, 8'h00);
        n_total++; if (done_0 !== 1'b1 || out_valid_0 !== 1'b0)
            $display("FAIL done_on_deleted: got done=%b v=%b want done=1 v=0", done_0, out_valid_0); else n_pass++;
        @(negedge clk);
        n_total++; if (done_0 !== 1'b0) $display("FAIL done_single: got %b want 0", done_0); else n_pass++;
        g = mk(2'b00, 8'h50, 8'h51, 8'h01);
        send(1'b1, g, 1'b1, 8'h00);
        n_total++; if (done_0 !== 1'b1 || out_valid_0 !== 1'b1 || gene_out_0 !== g)
            $display("FAIL done_on_kept: got done=%b v=%b %h want done=1 v=1 %h", done_0, out_valid_0, gene_out_0, g); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_g [4];
        for (int i = 0; i < 4; i++) exp_g[i] = mk(2'b10, 8'(8'h60 + i), 8'h00, 8'(8'hA0 + i));
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_total++; if (out_valid_0 !== 1'b1 || gene_out_0 !== exp_g[i-1])
                    $display("FAIL b2b_%0d: got v=%b %h want v=1 %h", i - 1, out_valid_0, gene_out_0, exp_g[i-1]); else n_pass++;
            end
            if (i < 4) begin
                phase = 1'b0; gene_in = exp_g[i]; rnd = 8'hFF; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_start_stall();
        send(1'b0, mk(2'b00, 8'h6F, 8'h00, 8'h00), 1'b0, 8'hFF);
        n_total++; if (del_node_cnt_0 !== 8'd2) $display("FAIL pre_start_cnt: got %0d want 2", del_node_cnt_0); else n_pass++;
        out_ready = 1'b0;
        send(1'b0, mk(2'b01, 8'h70, 8'h00, 8'h00), 1'b0, 8'h00);
        n_total++; if (out_valid_0 !== 1'b1 || in_ready_0 !== 1'b0)
            $display("FAIL pre_start_stall: got v=%b rdy=%b want v=1 rdy=0", out_valid_0, in_ready_0); else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; node_del_prob = 8'h00; conn_del_prob = 8'hFF;
        phase = 1'b0; gene_in = mk(2'b01, 8'h71, 8'h00, 8'h00); rnd = 8'h00; in_valid = 1'b1;
        #1;
        n_total++; if (in_ready_0 !== 1'b0) $display("FAIL start_blocks_ready: got %b want 0", in_ready_0); else n_pass++;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        n_total++; if (out_valid_0 !== 1'b0 || out_valid_1 !== 1'b0)
            $display("FAIL start_clears_valid: got %b/%b want 0/0", out_valid_0, out_valid_1); else n_pass++;
        n_total++; if (del_node_cnt_0 !== 8'd0 || del_conn_cnt_0 !== 8'd0 || list_full_0 !== 1'b0)
            $display("FAIL start_clears_cnt: got %0d/%0d full=%b want 0/0 full=0",
                     del_node_cnt_0, del_conn_cnt_0, list_full_0); else n_pass++;
    endtask

    task automatic test_rst_midstream();
        do_start(8'h00, 8'hFF);
        send(1'b0, mk(2'b00, 8'h44, 8'h00, 8'h00), 1'b0, 8'hFF);
        @(negedge clk);
        phase = 1'b1; gene_in = mk(2'b00, 8'h44, 8'h45, 8'h01); in_last = 1'b1; rnd = 8'h00;
        in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        n_total++; if (done_0 !== 1'b0 || out_valid_0 !== 1'b0)
            $display("FAIL rst_abort: got done=%b v=%b want 0/0", done_0, out_valid_0); else n_pass++;
        n_total++; if (del_node_cnt_0 !== 8'd0 || del_conn_cnt_0 !== 8'd0)
            $display("FAIL rst_abort_cnt: got %0d/%0d want 0/0", del_node_cnt_0, del_conn_cnt_0); else n_pass++;
        @(negedge clk);
        n_total++; if (done_0 !== 1'b0) $display("FAIL rst_no_done: got %b want 0", done_0); else n_pass++;
    endtask

    // Test sequence and summary.
    initial begin
        test_reset();
        test_node_conn_delete();
        test_node_keep();
        test_list_full();
        test_stall();
        test_empty_list();
        test_done();
        test_back_to_back();
        test_start_stall();
        test_rst_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
